// File: rtl/player_motion.sv
// ---------------------------------------------------------------------------
// player_motion
//   Per-character motion controller. Once per video frame (a single-cycle
//   tick recovered from the asynchronous frame_clk strobe) it applies the
//   decoded key word and the level-map collision flags to the character's
//   position, vertical velocity and jump state. It also drives the sprite
//   position, facing and animation state to the renderer.
//
// Ports
//   Clk          in   1   system clock, the only clock
//   Reset        in   1   synchronous, active-high reset
//   frame_clk    in   1   vsync-derived frame strobe, asynchronous to Clk
//   keycode      in  16   [15:8] jump key, [7:0] resolved horizontal key
//   ground_hit   in   1   solid tile directly below the character
//   ceiling_hit  in   1   solid tile directly above the character
//   wall_left    in   1   solid tile directly left of the character
//   wall_right   in   1   solid tile directly right of the character
//   pos_x        out 10   character x, unsigned pixels
//   pos_y        out 10   character y, unsigned pixels
//   facing       out  1   0 = right, 1 = left
//   anim_state   out  2   0 idle, 1 run, 2 rise, 3 fall
// ---------------------------------------------------------------------------
module player_motion #(
    parameter logic [7:0]  UP_KEY    = 8'h52,
    parameter logic [7:0]  LEFT_KEY  = 8'h50,
    parameter logic [7:0]  RIGHT_KEY = 8'h4F,
    parameter int unsigned X_INIT    = 64,
    parameter int unsigned Y_FLOOR   = 400,
    parameter int unsigned X_MIN     = 16,
    parameter int unsigned X_MAX     = 608,
    parameter int unsigned H_STEP    = 2,
    parameter int unsigned JUMP_V    = 10,
    parameter int unsigned GRAVITY   = 1,
    parameter int unsigned MAX_FALL  = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [15:0] keycode,
    input  logic        ground_hit,
    input  logic        ceiling_hit,
    input  logic        wall_left,
    input  logic        wall_right,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        facing,
    output logic [1:0]  anim_state
);

    localparam logic [9:0] X_INIT_C   = 10'(X_INIT);
    localparam logic [9:0] Y_FLOOR_C  = 10'(Y_FLOOR);
    localparam logic [9:0] X_MIN_C    = 10'(X_MIN);
    localparam logic [9:0] X_MAX_C    = 10'(X_MAX);
    localparam logic [9:0] H_STEP_C   = 10'(H_STEP);
    localparam logic [5:0] JUMP_V_C   = 6'(JUMP_V);
    localparam logic [5:0] GRAVITY_C  = 6'(GRAVITY);
    localparam logic [5:0] MAX_FALL_C = 6'(MAX_FALL);

    localparam logic [1:0] ANIM_IDLE = 2'd0;
    localparam logic [1:0] ANIM_RUN  = 2'd1;
    localparam logic [1:0] ANIM_RISE = 2'd2;
    localparam logic [1:0] ANIM_FALL = 2'd3;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } vstate_e;

    // -----------------------------------------------------------------------
    // Frame strobe synchroniser and rising-edge detector
    // -----------------------------------------------------------------------
    logic fsync1_q, fsync2_q, fprev_q;
    logic tick;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fsync1_q <= 1'b0;
            fsync2_q <= 1'b0;
            fprev_q  <= 1'b0;
        end else begin
            fsync1_q <= frame_clk;
            fsync2_q <= fsync1_q;
            fprev_q  <= fsync2_q;
        end
    end

    assign tick = fsync2_q & ~fprev_q;

    // -----------------------------------------------------------------------
    // Motion state
    // -----------------------------------------------------------------------
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [5:0] vy_q, vy_d;
    vstate_e    state_q, state_d;
    logic       facing_q, facing_d;
    logic [1:0] anim_q, anim_d;
    logic       armed_q, armed_d;

    // Key decode
    logic up, left, right;
    assign up    = (keycode[15:8] == UP_KEY);
    assign left  = (keycode[7:0]  == LEFT_KEY);
    assign right = (keycode[7:0]  == RIGHT_KEY);

    // Saturating arithmetic helpers; widened sums so clamps see true values
    logic [9:0]  x_diff;
    logic [10:0] x_sum;
    logic [9:0]  y_diff;
    logic [10:0] y_sum;
    logic [5:0]  vy_diff;
    logic [6:0]  vy_sum;

    assign x_diff  = (x_q > H_STEP_C) ? (x_q - H_STEP_C) : '0;
    assign x_sum   = {1'b0, x_q} + {1'b0, H_STEP_C};
    assign y_diff  = (y_q > {4'b0, vy_q}) ? (y_q - {4'b0, vy_q}) : '0;
    assign y_sum   = {1'b0, y_q} + {5'b0, vy_q};
    assign vy_diff = (vy_q > GRAVITY_C) ? (vy_q - GRAVITY_C) : '0;
    assign vy_sum  = {1'b0, vy_q} + {1'b0, GRAVITY_C};

    logic moved;

    // -----------------------------------------------------------------------
    // Next-state: horizontal motion, vertical FSM, jump arming, animation
    // -----------------------------------------------------------------------
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        vy_d     = vy_q;
        state_d  = state_q;
        facing_d = facing_q;
        armed_d  = armed_q;
        anim_d   = anim_q;
        moved    = 1'b0;

        // Horizontal: facing follows the key even when a wall blocks motion
        if (left) begin
            facing_d = 1'b1;
            if (!wall_left) begin
                x_d = (x_diff < X_MIN_C) ? X_MIN_C : x_diff;
            end
        end else if (right) begin
            facing_d = 1'b0;
            if (!wall_right) begin
                x_d = (x_sum > {1'b0, X_MAX_C}) ? X_MAX_C : x_sum[9:0];
            end
        end
        moved = (x_d != x_q);

        unique case (state_q)
            ST_GROUND: begin
                if (up && armed_q) begin
                    state_d = ST_RISE;
                    vy_d    = JUMP_V_C;
                    armed_d = 1'b0;
                end else if (!ground_hit && (y_q < Y_FLOOR_C)) begin
                    state_d = ST_FALL;
                    vy_d    = '0;
                end
            end
            ST_RISE: begin
                if (ceiling_hit || (vy_q == '0)) begin
                    state_d = ST_FALL;
                    vy_d    = '0;
                end else begin
                    y_d  = y_diff;
                    vy_d = vy_diff;
                end
            end
            ST_FALL: begin
                if (ground_hit || (y_q >= Y_FLOOR_C)) begin
                    state_d = ST_GROUND;
                    vy_d    = '0;
                    y_d     = (y_q > Y_FLOOR_C) ? Y_FLOOR_C : y_q;
                end else begin
                    y_d  = (y_sum > {1'b0, Y_FLOOR_C}) ? Y_FLOOR_C : y_sum[9:0];
                    vy_d = (vy_sum > {1'b0, MAX_FALL_C}) ? MAX_FALL_C : vy_sum[5:0];
                end
            end
            default: begin
                state_d = ST_GROUND;
                vy_d    = '0;
            end
        endcase

        // Re-arm only once the jump key has been released, so a held key
        // never re-jumps after landing
        if (!up) begin
            armed_d = 1'b1;
        end

        unique case (state_d)
            ST_RISE: anim_d = ANIM_RISE;
            ST_FALL: anim_d = ANIM_FALL;
            default: anim_d = moved ? ANIM_RUN : ANIM_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_q      <= X_INIT_C;
            y_q      <= Y_FLOOR_C;
            vy_q     <= '0;
            state_q  <= ST_GROUND;
            facing_q <= 1'b0;
            anim_q   <= ANIM_IDLE;
            armed_q  <= 1'b1;
        end else if (tick) begin
            x_q      <= x_d;
            y_q      <= y_d;
            vy_q     <= vy_d;
            state_q  <= state_d;
            facing_q <= facing_d;
            anim_q   <= anim_d;
            armed_q  <= armed_d;
        end
    end

    assign pos_x      = x_q;
    assign pos_y      = y_q;
    assign facing     = facing_q;
    assign anim_state = anim_q;

endmodule

// File: tb/tb_player_motion.sv
// ---------------------------------------------------------------------------
// tb_player_motion
//   Directed bench for player_motion. A behavioural model (plain integer
//   arithmetic on position/velocity/phase) is stepped when a frame tick is
//   due, and a compare process checks every DUT output against it on every
//   falling Clk edge. Hand-computed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_player_motion;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [15:0] keycode = 16'h0000;
    logic        ground_hit = 1'b1;
    logic        ceiling_hit = 1'b0;
    logic        wall_left = 1'b0;
    logic        wall_right = 1'b0;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        facing;
    logic [1:0]  anim_state;

    player_motion dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .keycode    (keycode),
        .ground_hit (ground_hit),
        .ceiling_hit(ceiling_hit),
        .wall_left  (wall_left),
        .wall_right (wall_right),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .facing     (facing),
        .anim_state (anim_state)
    );

    always #5 Clk = ~Clk;

    // ---------------- behavioural model ----------------
    localparam int PH_GROUND = 0;
    localparam int PH_RISE   = 1;
    localparam int PH_FALL   = 2;

    int m_x, m_y, m_vy, m_ph, m_face, m_anim, m_armed;
    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic void model_reset();
        m_x = 64; m_y = 400; m_vy = 0; m_ph = PH_GROUND;
        m_face = 0; m_anim = 0; m_armed = 1;
    endfunction

    function automatic void model_step();
        bit up, lf, rt;
        int nx;
        up = (keycode[15:8] == 8'h52);
        lf = (keycode[7:0] == 8'h50);
        rt = (keycode[7:0] == 8'h4F);
        nx = m_x;
        if (lf) begin
            m_face = 1;
            if (!wall_left) nx = imax(m_x - 2, 16);
        end else if (rt) begin
            m_face = 0;
            if (!wall_right) nx = imin(m_x + 2, 608);
        end
        case (m_ph)
            PH_GROUND: begin
                if (up && m_armed == 1) begin
                    m_ph = PH_RISE; m_vy = 10; m_armed = 0;
                end else if (!ground_hit && m_y < 400) begin
                    m_ph = PH_FALL; m_vy = 0;
                end
            end
            PH_RISE: begin
                if (ceiling_hit || m_vy == 0) begin
                    m_ph = PH_FALL; m_vy = 0;
                end else begin
                    m_y  = imax(m_y - m_vy, 0);
                    m_vy = imax(m_vy - 1, 0);
                end
            end
            default: begin
                if (ground_hit || m_y >= 400) begin
                    m_ph = PH_GROUND; m_vy = 0; m_y = imin(m_y, 400);
                end else begin
                    m_y  = imin(m_y + m_vy, 400);
                    m_vy = imin(m_vy + 1, 8);
                end
            end
        endcase
        if (!up) m_armed = 1;
        if (m_ph == PH_RISE)      m_anim = 2;
        else if (m_ph == PH_FALL) m_anim = 3;
        else                      m_anim = (nx != m_x) ? 1 : 0;
        m_x = nx;
    endfunction

    function automatic void check(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Per-cycle comparison against the model
    always @(negedge Clk) begin
        if (chk_en) begin
            check("pos_x", int'(pos_x), m_x);
            check("pos_y", int'(pos_y), m_y);
            check("facing", int'(facing), m_face);
            check("anim_state", int'(anim_state), m_anim);
        end
    end

    // One frame: frame_clk rises before edge E0, the motion registers
    // update on E2 (the third edge counting E0), then the strobe drops and
    // the synchroniser is allowed to drain.
    task automatic frame_tick();
        @(negedge Clk) frame_clk = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        @(posedge Clk);
        #1 model_step();
        @(negedge Clk) frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) frame_tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge Clk);
        check("reset_x", int'(pos_x), 64);
        check("reset_y", int'(pos_y), 400);

        // 1: idle frames
        keycode = 16'h0000;
        ticks(3);
        check("idle_x", int'(pos_x), 64);
        check("idle_anim", int'(anim_state), 0);

        // 2: run left into the X_MIN clamp
        keycode = 16'h0050;
        for (int i = 1; i <= 30; i++) begin
            frame_tick();
            if (i == 24) begin
                check("left24_x", int'(pos_x), 16);
                check("left24_anim", int'(anim_state), 1);
            end
        end
        check("left30_x", int'(pos_x), 16);
        check("left30_face", int'(facing), 1);
        check("left30_anim", int'(anim_state), 0);

        // 3: jump, apex, fall, held-key lockout, re-press
        keycode = 16'h5200;
        frame_tick();
        check("jump1_anim", int'(anim_state), 2);
        check("jump1_y", int'(pos_y), 400);
        ground_hit = 1'b0;
        ticks(10);
        check("apex_y", int'(pos_y), 345);
        frame_tick();
        check("fall_anim", int'(anim_state), 3);
        check("fall_y", int'(pos_y), 345);
        ticks(14);
        check("landed_y", int'(pos_y), 400);
        check("landed_anim", int'(anim_state), 0);
        ticks(3);
        check("held_anim", int'(anim_state), 0);
        keycode = 16'h0000;
        frame_tick();
        keycode = 16'h5200;
        frame_tick();
        check("rejump_anim", int'(anim_state), 2);

        // 4: ceiling mid-rise, mid-air landing, walk-off fall
        ticks(2);
        check("rise2_y", int'(pos_y), 381);
        ceiling_hit = 1'b1;
        frame_tick();
        ceiling_hit = 1'b0;
        check("ceil_anim", int'(anim_state), 3);
        check("ceil_y", int'(pos_y), 381);
        ticks(2);
        check("ceilfall_y", int'(pos_y), 382);
        ground_hit = 1'b1;
        frame_tick();
        check("ledge_anim", int'(anim_state), 0);
        ground_hit = 1'b0;
        keycode = 16'h0000;
        frame_tick();
        check("walkoff_anim", int'(anim_state), 3);

        // 6: reset during FALL, coincident with a frame_clk rise
        @(negedge Clk);
        Reset = 1'b1;
        frame_clk = 1'b1;
        @(posedge Clk);
        #1 model_reset();
        @(negedge Clk);
        @(negedge Clk) frame_clk = 1'b0;
        keycode = 16'h0050;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (8) @(negedge Clk);
        check("rst_x", int'(pos_x), 64);
        check("rst_y", int'(pos_y), 400);
        check("rst_anim", int'(anim_state), 0);
        check("rst_face", int'(facing), 0);

        // 5: walls
        ground_hit = 1'b1;
        wall_left  = 1'b1;
        frame_tick();
        check("wl_x", int'(pos_x), 64);
        check("wl_face", int'(facing), 1);
        wall_left  = 1'b0;
        wall_right = 1'b1;
        keycode    = 16'h004F;
        ticks(3);
        check("wr_x", int'(pos_x), 64);
        check("wr_face", int'(facing), 0);
        check("wr_anim", int'(anim_state), 0);
        wall_right = 1'b0;
        ticks(4);
        check("right_x", int'(pos_x), 72);
        check("right_anim", int'(anim_state), 1);

        // Jump while moving right: rise wins the animation, x still moves
        keycode = 16'h524F;
        frame_tick();
        check("jr_x", int'(pos_x), 74);
        check("jr_anim", int'(anim_state), 2);
        keycode = 16'h0051;
        ground_hit = 1'b0;
        ticks(30);
        check("jr_land_y", int'(pos_y), 400);
        check("jr_land_x", int'(pos_x), 74);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
